// File: rtl/lcd12864_text_ctrl.sv
// ST7920 128x64 text-mode controller: holds a ROWS x COLS character buffer and streams it over the 8-bit parallel bus.
// Optional backlight PWM is enabled by defining LCD_BACKLIGHT_PWM_EN (adds the bl_level input).
module lcd12864_text_ctrl #(
    parameter int ROWS         = 4,
    parameter int COLS         = 16,
    parameter int E_HIGH       = 25,
    parameter int CMD_WAIT     = 4000,
    parameter int CLR_WAIT     = 80000,
    parameter int RST_CYC      = 50000,
    parameter int AUTO_REFRESH = 0
) (
    input  logic                            clk,
    input  logic                            rst,
`ifdef LCD_BACKLIGHT_PWM_EN
    input  logic [7:0]                      bl_level,
`endif
    input  logic                            wr_en,
    input  logic [$clog2(ROWS*COLS)-1:0]    wr_addr,
    input  logic [7:0]                      wr_data,
    input  logic                            refresh,
    output logic                            busy,
    output logic                            init_done,
    output logic                            lcd_rs,
    output logic                            lcd_rw,
    output logic                            lcd_en,
    output logic [7:0]                      lcd_dat,
    output logic                            lcd_rst,
    output logic                            lcd_psb,
    output logic                            lcd_bl_p,
    output logic                            lcd_bl_n
);

    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW   = $clog2(COLS);
    localparam int M1    = (CLR_WAIT > RST_CYC) ? CLR_WAIT : RST_CYC;
    localparam int M2    = (CMD_WAIT > E_HIGH) ? CMD_WAIT : E_HIGH;
    localparam int MAXC  = (M1 > M2) ? M1 : M2;
    localparam int CW    = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_RST_HOLD,
        S_RST_WAIT,
        S_INIT,
        S_IDLE,
        S_ROW_ADDR,
        S_ROW_DATA
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_EHI,
        PH_WAIT
    } phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CLW-1:0]  col_q, col_d;
    logic [1:0]      init_idx_q, init_idx_d;
    logic            en_q, en_d;
    logic            rs_q, rs_d;
    logic [7:0]      dat_q, dat_d;
    logic            lrst_q, lrst_d;
    logic            init_done_q, init_done_d;
    logic            pend_q, pend_d;
    logic            byte_done;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];

    // DDRAM row start addresses of the ST7920 (rows 2/3 interleave with 0/1)
    function automatic logic [7:0] row_base(input logic [RW-1:0] r);
        case (int'(r))
            1:       row_base = 8'h10;
            2:       row_base = 8'h08;
            3:       row_base = 8'h18;
            default: row_base = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    init_cmd = 8'h30;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    function automatic logic [AW-1:0] buf_idx(input logic [RW-1:0] r, input logic [CLW-1:0] c);
        buf_idx = AW'(int'(r) * COLS + int'(c));
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        init_idx_d  = init_idx_q;
        en_d        = en_q;
        rs_d        = rs_q;
        dat_d       = dat_q;
        lrst_d      = lrst_q;
        init_done_d = init_done_q;
        pend_d      = pend_q;
        byte_done   = 1'b0;

        if (refresh && (state_q != S_IDLE)) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_RST_HOLD: begin
                if (cnt_q == '0) begin
                    lrst_d  = 1'b1;
                    cnt_d   = CW'(CLR_WAIT - 1);
                    state_d = S_RST_WAIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = S_INIT;
                    init_idx_d = 2'd0;
                    rs_d       = 1'b0;
                    dat_d      = init_cmd(2'd0);
                    phase_d    = PH_SETUP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_IDLE: begin
                if (pend_q || refresh || (AUTO_REFRESH != 0)) begin
                    pend_d  = 1'b0;
                    state_d = S_ROW_ADDR;
                    row_d   = '0;
                    rs_d    = 1'b0;
                    dat_d   = 8'h80 | row_base('0);
                    phase_d = PH_SETUP;
                end
            end
            default: begin
                // Shared byte engine: setup cycle, E high, then post-byte wait
                case (phase_q)
                    PH_SETUP: begin
                        en_d    = 1'b1;
                        cnt_d   = CW'(E_HIGH - 1);
                        phase_d = PH_EHI;
                    end
                    PH_EHI: begin
                        if (cnt_q == '0) begin
                            en_d    = 1'b0;
                            phase_d = PH_WAIT;
                            cnt_d   = (!rs_q && (dat_q == 8'h01)) ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    PH_WAIT: begin
                        if (cnt_q == '0) begin
                            byte_done = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    default: phase_d = PH_SETUP;
                endcase

                if (byte_done) begin
                    phase_d = PH_SETUP;
                    case (state_q)
                        S_INIT: begin
                            if (init_idx_q == 2'd3) begin
                                state_d     = S_IDLE;
                                init_done_d = 1'b1;
                            end else begin
                                init_idx_d = init_idx_q + 2'd1;
                                dat_d      = init_cmd(init_idx_q + 2'd1);
                            end
                        end
                        S_ROW_ADDR: begin
                            state_d = S_ROW_DATA;
                            col_d   = '0;
                            rs_d    = 1'b1;
                            dat_d   = mem_q[buf_idx(row_q, '0)];
                        end
                        S_ROW_DATA: begin
                            if (col_q != CLW'(COLS - 1)) begin
                                col_d = col_q + 1'b1;
                                dat_d = mem_q[buf_idx(row_q, col_q + 1'b1)];
                            end else if (row_q != RW'(ROWS - 1)) begin
                                state_d = S_ROW_ADDR;
                                row_d   = row_q + 1'b1;
                                rs_d    = 1'b0;
                                dat_d   = 8'h80 | row_base(row_q + 1'b1);
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RST_HOLD;
            phase_q     <= PH_SETUP;
            cnt_q       <= CW'(RST_CYC - 1);
            row_q       <= '0;
            col_q       <= '0;
            init_idx_q  <= '0;
            en_q        <= 1'b0;
            rs_q        <= 1'b0;
            dat_q       <= 8'h00;
            lrst_q      <= 1'b0;
            init_done_q <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            init_idx_q  <= init_idx_d;
            en_q        <= en_d;
            rs_q        <= rs_d;
            dat_q       <= dat_d;
            lrst_q      <= lrst_d;
            init_done_q <= init_done_d;
            pend_q      <= pend_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h20;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

`ifdef LCD_BACKLIGHT_PWM_EN
    logic [7:0] pwm_cnt_q, pwm_cnt_d;
    logic [7:0] lvl_q, lvl_d;

    // Level only changes at the wrap so each 256-cycle period has a clean duty
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        lvl_d     = (pwm_cnt_q == 8'hFF) ? bl_level : lvl_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= 8'd0;
            lvl_q     <= 8'd0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            lvl_q     <= lvl_d;
        end
    end

    assign lcd_bl_p = (pwm_cnt_q < lvl_q);
`else
    assign lcd_bl_p = 1'b1;
`endif

    assign busy      = (state_q != S_IDLE) || pend_q || (AUTO_REFRESH != 0);
    assign init_done = init_done_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = en_q;
    assign lcd_dat   = dat_q;
    assign lcd_rst   = lrst_q;
    assign lcd_psb   = 1'b1;
    assign lcd_bl_n  = 1'b0;

endmodule

// File: tb/tb_lcd12864_text_ctrl.sv
// Scoreboard bench for lcd12864_text_ctrl: expected bus bytes are queued with the stimulus and matched against captured E strobes.
`timescale 1ns/1ps
module tb_lcd12864_text_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'd0;
    logic       refresh = 1'b0;
`ifdef LCD_BACKLIGHT_PWM_EN
    logic [7:0] bl_level = 8'd0;
`endif
    logic       busy, init_done, lcd_rs, lcd_rw, lcd_en, lcd_rst, lcd_psb, lcd_bl_p, lcd_bl_n;
    logic [7:0] lcd_dat;

    lcd12864_text_ctrl #(
        .ROWS(2), .COLS(4), .E_HIGH(2), .CMD_WAIT(4), .CLR_WAIT(10), .RST_CYC(8), .AUTO_REFRESH(0)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef LCD_BACKLIGHT_PWM_EN
        .bl_level(bl_level),
`endif
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .refresh(refresh),
        .busy(busy),
        .init_done(init_done),
        .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw),
        .lcd_en(lcd_en),
        .lcd_dat(lcd_dat),
        .lcd_rst(lcd_rst),
        .lcd_psb(lcd_psb),
        .lcd_bl_p(lcd_bl_p),
        .lcd_bl_n(lcd_bl_n)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    int         hi_q[$];
    int         gap_q[$];
    logic       en_prev = 1'b0;
    int         hi_len = 0;
    int         lo_len = 0;

    logic [7:0] row0_txt [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
    logic [7:0] row1_txt [4] = '{8'h77, 8'h78, 8'h79, 8'h7A};

    // Bus monitor: one entry per E rising edge, plus E-high and E-low run lengths
    always @(negedge clk) begin
        if (rst) begin
            en_prev = 1'b0;
            hi_len  = 0;
            lo_len  = 0;
        end else begin
            if (lcd_en && !en_prev) begin
                obs_q.push_back({lcd_rs, lcd_dat});
                gap_q.push_back(lo_len);
                hi_len = 1;
            end else if (lcd_en) begin
                hi_len++;
            end else if (en_prev) begin
                hi_q.push_back(hi_len);
                lo_len = 1;
            end else begin
                lo_len++;
            end
            en_prev = lcd_en;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic get_obs(output logic [8:0] v, output bit ok);
        int n;
        ok = 1'b0;
        v  = '0;
        n  = 0;
        while (!ok && n < 400) begin
            if (obs_q.size() > 0) begin
                v  = obs_q.pop_front();
                ok = 1'b1;
            end else begin
                @(negedge clk);
                #1;
                n++;
            end
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        @(posedge clk);
        #1;
        refresh = 1'b0;
    endtask

    task automatic push_pass(input logic [7:0] r0 [4], input logic [7:0] r1 [4]);
        exp_q.push_back(9'h080);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, r0[i]});
        exp_q.push_back(9'h090);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, r1[i]});
    endtask

    task automatic test_reset();
        int n;
        repeat (3) @(negedge clk);
        total++;
        if ({lcd_en, lcd_rs, lcd_rw, lcd_dat} !== 11'h000) begin
            bad++;
            $display("FAIL reset_bus: en/rs/rw/dat=%03h want 000", {lcd_en, lcd_rs, lcd_rw, lcd_dat});
        end
        total++;
        if ({lcd_rst, lcd_psb, lcd_bl_n, lcd_bl_p} !== 4'b0101) begin
            bad++;
            $display("FAIL reset_pins: rst/psb/bl_n/bl_p=%b want 0101", {lcd_rst, lcd_psb, lcd_bl_n, lcd_bl_p});
        end
        total++;
        if ({busy, init_done} !== 2'b10) begin
            bad++;
            $display("FAIL reset_status: busy/init_done=%b want 10", {busy, init_done});
        end
        rst = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (lcd_rst) break;
        end
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL rst_hold_len: lcd_rst rose after %0d cycles want 8", n);
        end
    endtask

    task automatic test_init();
        logic [8:0] e, o;
        bit ok;
        int n;
        exp_q.push_back(9'h030);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_obs(o, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL init_byte: timeout want %03h", e);
            end else if (o !== e) begin
                bad++;
                $display("FAIL init_byte: got %03h want %03h", o, e);
            end
        end
        n = 0;
        while (lcd_en && n < 100) begin @(negedge clk); #1; n++; end
        n = 0;
        while (!init_done && n < 100) begin n++; @(negedge clk); #1; end
        total++;
        if (n != 10) begin
            bad++;
            $display("FAIL clr_wait: init_done after %0d idle cycles want 10", n);
        end
        total++;
        if ({busy, init_done} !== 2'b01) begin
            bad++;
            $display("FAIL init_status: busy/init_done=%b want 01", {busy, init_done});
        end
        total++;
        if (gap_q.size() < 2 || gap_q[1] != 5) begin
            bad++;
            $display("FAIL cmd_gap: gap before 0x0C=%0d want 5", (gap_q.size() < 2) ? -1 : gap_q[1]);
        end
        for (int i = 0; i < hi_q.size(); i++) begin
            total++;
            if (hi_q[i] != 2) begin
                bad++;
                $display("FAIL init_en_width: byte %0d en high %0d want 2", i, hi_q[i]);
            end
        end
    endtask

    task automatic test_pass();
        logic [8:0] e, o;
        bit ok;
        int n;
        for (int i = 0; i < 4; i++) wr(3'(i), row0_txt[i]);
        for (int i = 0; i < 4; i++) wr(3'(i + 4), row1_txt[i]);
        hi_q.delete();
        push_pass(row0_txt, row1_txt);
        pulse_refresh();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_obs(o, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL pass_byte: timeout want %03h", e);
            end else if (o !== e) begin
                bad++;
                $display("FAIL pass_byte: got %03h want %03h", o, e);
            end
        end
        n = 0;
        while (lcd_en && n < 100) begin @(negedge clk); #1; n++; end
        n = 0;
        while (busy && n < 100) begin n++; @(negedge clk); #1; end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL busy_tail: busy dropped after %0d cycles want 4", n);
        end
        total++;
        if (hi_q.size() != 10) begin
            bad++;
            $display("FAIL pass_strobes: %0d strobes want 10", hi_q.size());
        end
        for (int i = 0; i < hi_q.size(); i++) begin
            total++;
            if (hi_q[i] != 2) begin
                bad++;
                $display("FAIL pass_en_width: byte %0d en high %0d want 2", i, hi_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] e, o;
        bit ok;
        int n;
        push_pass(row0_txt, row1_txt);
        push_pass(row0_txt, row1_txt);
        pulse_refresh();
        repeat (3) @(negedge clk);
        pulse_refresh();
        repeat (2) @(negedge clk);
        pulse_refresh();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_obs(o, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL b2b_byte: timeout want %03h", e);
            end else if (o !== e) begin
                bad++;
                $display("FAIL b2b_byte: got %03h want %03h", o, e);
            end
        end
        n = 0;
        while (busy && n < 200) begin @(negedge clk); #1; n++; end
        repeat (60) @(negedge clk);
        #1;
        total++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: extra bytes=%0d busy=%b want 0 and 0", obs_q.size(), busy);
        end
    endtask

    task automatic test_midwrite();
        logic [8:0] e, o;
        logic [7:0] r1 [4];
        bit ok;
        int i, n;
        r1 = '{8'h77, 8'h78, 8'h79, 8'h51};
        push_pass(row0_txt, r1);
        pulse_refresh();
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_obs(o, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL midwrite_byte: timeout want %03h", e);
            end else if (o !== e) begin
                bad++;
                $display("FAIL midwrite_byte: got %03h want %03h", o, e);
            end
            if (i == 6) wr(3'd7, 8'h51);
            i++;
        end
        n = 0;
        while (busy && n < 200) begin @(negedge clk); #1; n++; end
    endtask

    task automatic test_reset_mid();
        logic [8:0] e, o;
        logic [7:0] blank [4];
        bit ok;
        int n;
        blank = '{8'h20, 8'h20, 8'h20, 8'h20};
        exp_q.push_back(9'h080);
        exp_q.push_back(9'h141);
        exp_q.push_back(9'h142);
        pulse_refresh();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_obs(o, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL abort_prefix: timeout want %03h", e);
            end else if (o !== e) begin
                bad++;
                $display("FAIL abort_prefix: got %03h want %03h", o, e);
            end
        end
        total++;
        if (lcd_en !== 1'b1) begin
            bad++;
            $display("FAIL abort_setup: en=%b want 1 before reset", lcd_en);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({lcd_en, lcd_rst, lcd_rs, lcd_dat, busy, init_done} !== 13'b0_0_0_00000000_1_0) begin
            bad++;
            $display("FAIL abort_now: en/rst/rs/dat/busy/init=%b want 0000000000010",
                     {lcd_en, lcd_rst, lcd_rs, lcd_dat, busy, init_done});
        end
        repeat (2) @(negedge clk);
        obs_q.delete();
        gap_q.delete();
        hi_q.delete();
        rst = 1'b0;
        pulse_refresh();
        exp_q.push_back(9'h030);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
        push_pass(blank, blank);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_obs(o, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL restart_byte: timeout want %03h", e);
            end else if (o !== e) begin
                bad++;
                $display("FAIL restart_byte: got %03h want %03h", o, e);
            end
        end
        n = 0;
        while (busy && n < 200) begin @(negedge clk); #1; n++; end
        total++;
        if ({busy, init_done} !== 2'b01) begin
            bad++;
            $display("FAIL restart_status: busy/init_done=%b want 01", {busy, init_done});
        end
    endtask

`ifdef LCD_BACKLIGHT_PWM_EN
    task automatic test_backlight();
        int hi;
        bl_level = 8'd64;
        repeat (600) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (lcd_bl_p) hi++;
        end
        total++;
        if (hi != 64) begin
            bad++;
            $display("FAIL bl_duty: high %0d of 256 want 64", hi);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_init();
        test_pass();
        test_back_to_back();
        test_midwrite();
        test_reset_mid();
`ifdef LCD_BACKLIGHT_PWM_EN
        test_backlight();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
